// File: rtl/adc_trig_capture.sv
// ADC trigger capture: circular pre/post-trigger record buffer with valid/ready readout.
// The record is DEPTH samples around a level/edge (or forced) trigger, streamed out oldest-first.
module adc_trig_capture #(
  parameter int DATA_W     = 12,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     adc_data,
  input  logic                  adc_valid,
  input  logic                  arm,
  input  logic                  force_trig,
  input  logic [DATA_W-1:0]     trig_level,
  input  logic                  trig_edge,
  input  logic [DEPTH_LOG2-1:0] pre_len,
  input  logic                  rd_ready,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  output logic                  busy,
  output logic                  done,
  output logic [DEPTH_LOG2-1:0] trig_pos
);

  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH_M1 = CW'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, PRE_FILL, WAIT_TRIG, POST_FILL, READOUT} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DATA_W-1:0]     mem_q;
  logic [DATA_W-1:0]     prev_sample;
  logic                  prev_vld;
  logic                  force_pend;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] p_len;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic [CW-1:0]         wr_cnt;
  logic [CW-1:0]         wr_cnt_inc;
  logic [CW-1:0]         rd_cnt;
  logic [CW-1:0]         post_len;
  logic [1:0]            vld_pipe;
  logic                  s1_last;
  logic                  wr_en;
  logic                  lvl_rise;
  logic                  lvl_fall;
  logic                  trig_hit;
  logic                  adv;
  logic                  issue;
  logic                  last_hs;

  assign post_len   = DEPTH_M1 - {1'b0, p_len};
  assign wr_cnt_inc = wr_cnt + CW'(1);
  assign wr_en      = adc_valid &&
                      (state == PRE_FILL || state == WAIT_TRIG || state == POST_FILL);

  // Level crossings need a real previous sample; force does not.
  assign lvl_rise = !trig_edge && prev_vld &&
                    (prev_sample < trig_level) && (adc_data >= trig_level);
  assign lvl_fall = trig_edge && prev_vld &&
                    (prev_sample > trig_level) && (adc_data <= trig_level);
  assign trig_hit = (state == WAIT_TRIG) && adc_valid &&
                    (force_trig || force_pend || lvl_rise || lvl_fall);

  // Two-stage read pipe (RAM register, output register) stalls as a unit.
  assign adv      = !rd_valid || rd_ready;
  assign issue    = (state == READOUT) && !rd_cnt[DEPTH_LOG2] && adv;
  assign rd_addr  = trig_pos - p_len + rd_cnt[DEPTH_LOG2-1:0];
  assign last_hs  = rd_valid && rd_ready && rd_last;
  assign rd_valid = vld_pipe[1];
  assign busy     = (state != IDLE);

  always_ff @(posedge clk_in) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (arm) state_nxt = (pre_len == '0) ? WAIT_TRIG : PRE_FILL;
      PRE_FILL:  if (wr_en && wr_cnt_inc == {1'b0, p_len}) state_nxt = WAIT_TRIG;
      WAIT_TRIG: if (trig_hit) state_nxt = (post_len == '0) ? READOUT : POST_FILL;
      POST_FILL: if (wr_en && wr_cnt_inc == post_len) state_nxt = READOUT;
      READOUT:   if (last_hs) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      wr_ptr      <= '0;
      p_len       <= '0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      prev_sample <= '0;
      prev_vld    <= 1'b0;
      force_pend  <= 1'b0;
      trig_pos    <= '0;
    end else begin
      if (state == IDLE && arm) begin
        p_len      <= pre_len;
        wr_ptr     <= '0;
        wr_cnt     <= '0;
        rd_cnt     <= '0;
        prev_vld   <= 1'b0;
        force_pend <= 1'b0;
      end
      if (wr_en) begin
        wr_ptr      <= wr_ptr + DEPTH_LOG2'(1);
        wr_cnt      <= wr_cnt_inc;
        prev_sample <= adc_data;
        prev_vld    <= 1'b1;
      end
      // Counter restarts at the trigger so it then counts post-trigger writes.
      if (trig_hit) begin
        trig_pos   <= wr_ptr;
        wr_cnt     <= '0;
        force_pend <= 1'b0;
      end else if (state == WAIT_TRIG && force_trig) begin
        force_pend <= 1'b1;
      end
      if (issue) rd_cnt <= rd_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_last  <= 1'b0;
      rd_data  <= '0;
      rd_last  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= last_hs;
      if (adv) begin
        vld_pipe <= {vld_pipe[0], issue};
        s1_last  <= issue && (rd_cnt == DEPTH_M1);
        rd_last  <= vld_pipe[0] && s1_last;
        if (vld_pipe[0]) rd_data <= mem_q;
      end
    end
  end

  // Sample RAM: no reset, read port enabled only when the pipe advances.
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_ptr] <= adc_data;
    if (issue) mem_q <= mem[rd_addr];
  end

endmodule

// File: tb/tb_adc_trig_capture.sv
// Scoreboard bench for adc_trig_capture at DEPTH=16: directed captures push
// expected records; a negedge monitor checks every handshake, stall and done pulse.
module tb_adc_trig_capture;
  localparam int DW    = 12;
  localparam int DL    = 4;
  localparam int DEPTH = 16;

  logic          clk_in = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] adc_data = '0;
  logic          adc_valid = 1'b0;
  logic          arm = 1'b0;
  logic          force_trig = 1'b0;
  logic [DW-1:0] trig_level = '0;
  logic          trig_edge = 1'b0;
  logic [DL-1:0] pre_len = '0;
  logic          rd_ready = 1'b1;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_last;
  logic          busy;
  logic          done;
  logic [DL-1:0] trig_pos;

  typedef struct {int data; bit last;} exp_t;
  exp_t exp_q[$];

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int done_cnt = 0;
  bit chk_done = 0, chk_done2 = 0, stall = 0, tog_mode = 0;
  int held_data;
  int held_last;

  adc_trig_capture #(.DATA_W(DW), .DEPTH_LOG2(DL)) dut (
    .clk_in(clk_in), .rst(rst), .adc_data(adc_data), .adc_valid(adc_valid),
    .arm(arm), .force_trig(force_trig), .trig_level(trig_level),
    .trig_edge(trig_edge), .pre_len(pre_len), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .busy(busy),
    .done(done), .trig_pos(trig_pos)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk_in); #1;
  endtask

  task automatic send(input int v);
    adc_valid = 1'b1;
    adc_data  = DW'(v);
    step();
    adc_valid = 1'b0;
  endtask

  task automatic do_arm(input int p, input int lvl, input bit edge_sel);
    pre_len    = DL'(p);
    trig_level = DW'(lvl);
    trig_edge  = edge_sel;
    arm = 1'b1;
    step();
    arm = 1'b0;
    chk("busy_after_arm", int'(busy), 1);
  endtask

  // Every directed record here is a run of consecutive values.
  task automatic push_rec(input int first);
    exp_t e;
    for (int i = 0; i < DEPTH; i++) begin
      e.data = first + i;
      e.last = (i == DEPTH - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input int tp, input bit poke_arm);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < 400) begin
      if (poke_arm) begin
        pre_len = '0;
        arm = rd_valid && (n % 7 == 3);
      end
      step();
      n++;
    end
    arm = 1'b0;
    if (done_cnt == start) chk("done_timeout", done_cnt - start, 1);
    chk("trig_pos", int'(trig_pos), tp);
    step();
    chk("busy_after_done", int'(busy), 0);
  endtask

  initial begin
    forever begin
      @(posedge clk_in); #1;
      if (tog_mode) rd_ready = ($time / 10) % 4 == 0 || ($time / 10) % 4 == 3;
      else          rd_ready = 1'b1;
    end
  end

  always @(negedge clk_in) begin : mon
    exp_t e;
    if (chk_done2) chk("done_one_cycle", int'(done), 0);
    chk_done2 = 0;
    if (chk_done) begin
      chk("done_pulse", int'(done), 1);
      chk("rd_valid_after_last", int'(rd_valid), 0);
      done_cnt++;
      chk_done2 = 1;
    end else if (done) begin
      chk("spurious_done", int'(done), 0);
    end
    chk_done = 0;
    if (stall) begin
      chk("stall_valid", int'(rd_valid), 1);
      chk("stall_data", int'(rd_data), held_data);
      chk("stall_last", int'(rd_last), held_last);
    end
    stall = 0;
    if (rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_sample", int'(rd_data), -1);
      end else begin
        e = exp_q.pop_front();
        chk("rd_data", int'(rd_data), e.data);
        chk("rd_last", int'(rd_last), int'(e.last));
        if (rd_last) chk_done = 1;
      end
    end else if (rd_valid) begin
      stall = 1;
      held_data = int'(rd_data);
      held_last = int'(rd_last);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) step();
    @(negedge clk_in);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_rd_last", int'(rd_last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_trig_pos", int'(trig_pos), 0);
    step();
    rst = 1'b0;
    step();

    // Rising ramp, P=4: trigger on 20 at address 4, record 16..31.
    do_arm(4, 20, 1'b0);
    push_rec(16);
    for (int v = 0; v < 32; v++) send(v);
    wait_done(4, 1'b0);

    // Falling edge never seen on a rising ramp; pending force fires on 41.
    do_arm(4, 20, 1'b1);
    push_rec(37);
    for (int v = 0; v <= 40; v++) send(v);
    chk("no_trig_busy", int'(busy), 1);
    chk("no_trig_rd_valid", int'(rd_valid), 0);
    force_trig = 1'b1;
    step();
    force_trig = 1'b0;
    for (int v = 41; v <= 52; v++) send(v);
    wait_done(9, 1'b0);

    // P=0: 50 cannot trigger (no prev), 5 is below, 15 crosses.
    do_arm(0, 10, 1'b0);
    push_rec(15);
    send(50);
    send(5);
    for (int v = 15; v <= 30; v++) send(v);
    wait_done(2, 1'b0);

    // P=15: post fill skipped, readout two cycles after entry, stalling consumer.
    tog_mode = 1'b1;
    do_arm(15, 100, 1'b0);
    push_rec(85);
    for (int v = 70; v <= 100; v++) send(v);
    @(negedge clk_in);
    chk("lat_cycle0", int'(rd_valid), 0);
    @(negedge clk_in);
    chk("lat_cycle1", int'(rd_valid), 0);
    @(negedge clk_in);
    chk("lat_cycle2", int'(rd_valid), 1);
    step();
    wait_done(14, 1'b0);
    tog_mode = 1'b0;

    // Reset during post fill aborts; rerun with arm pokes during readout.
    do_arm(4, 20, 1'b0);
    for (int v = 0; v <= 24; v++) send(v);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk_in);
    chk("abort_busy", int'(busy), 0);
    chk("abort_rd_valid", int'(rd_valid), 0);
    step();
    do_arm(4, 20, 1'b0);
    push_rec(16);
    for (int v = 0; v < 32; v++) send(v);
    wait_done(4, 1'b1);

    repeat (3) step();
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/adc_trig_capture.md
Name: adc_trig_capture

Overview:
- Capture side of the waveform path: takes the ADC sample stream, detects a level/edge trigger, and stores a pre/post-trigger window in an on-chip circular buffer.
- Streams the completed record out over a valid/ready interface toward the PS-side waveform path.
- Sits between the ADC driver user-side data and the Outside_Wave inputs of the processing-system wrapper, in the 100 MHz user clock domain.

Parameters:
- DATA_W, 12, sample width (unsigned offset-binary).
- DEPTH_LOG2, 10, log2 of record length; DEPTH = 2**DEPTH_LOG2 samples.

Ports:
- clk_in  input  1  user clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- adc_data  input  DATA_W  sample from ADC driver.
- adc_valid  input  1  adc_data valid this cycle.
- arm  input  1  single-cycle start request.
- force_trig  input  1  trigger immediately, regardless of level.
- trig_level  input  DATA_W  trigger threshold, unsigned.
- trig_edge  input  1  0 = rising, 1 = falling.
- pre_len  input  DEPTH_LOG2  pre-trigger sample count, latched on arm.
- rd_ready  input  1  consumer ready.
- rd_data  output  DATA_W  record sample.
- rd_valid  output  1  rd_data valid.
- rd_last  output  1  final sample of the record.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last sample handshake.
- trig_pos  output  DEPTH_LOG2  buffer address of the trigger sample in the last capture.

Behaviour:
- Reset: state IDLE. rd_data=0, rd_valid=0, rd_last=0, busy=0, done=0, trig_pos=0. Write pointer, counters and prev-sample valid flag cleared.
- Reset asserted in any state aborts the operation in the same cycle; buffer contents are don't-care.
- States: IDLE, PRE_FILL, WAIT_TRIG, POST_FILL, READOUT.
- Writes occur only on adc_valid=1 in PRE_FILL, WAIT_TRIG and POST_FILL. Each write stores the sample at wr_ptr, then wr_ptr increments mod DEPTH.
- IDLE:
  - arm=1: latch pre_len as P, set wr_ptr=0, enter PRE_FILL.
  - If P=0, enter WAIT_TRIG directly.
  - arm in any other state is ignored.
- PRE_FILL: count written samples; after the P-th write, enter WAIT_TRIG. Triggers are not evaluated in this state.
- WAIT_TRIG: circular overwrite continues. A trigger fires on a valid sample cur when any of:
  - force_trig=1, or
  - trig_edge=0 and prev<trig_level and cur>=trig_level, or
  - trig_edge=1 and prev>trig_level and cur<=trig_level.
- prev is the previous valid sample. The level comparisons require prev valid; prev is invalid for the first sample after arm, so no level trigger can fire on it. force_trig does not require prev valid.
- force_trig without adc_valid is held pending and fires on the next valid sample.
- On trigger: the trigger sample is written, trig_pos is set to its address, then enter POST_FILL.
- POST_FILL: write DEPTH-1-P further samples, then enter READOUT. If DEPTH-1-P = 0, go straight to READOUT.
- READOUT:
  - Read start address = trig_pos - P mod DEPTH; read DEPTH samples in address order with wrap-around.
  - The buffer is synchronous-read RAM with a registered output stage. The first rd_valid appears 2 cycles after READOUT entry.
  - Handshake occurs when rd_valid and rd_ready are both 1.
  - While rd_valid=1 and rd_ready=0, rd_data and rd_last hold stable.
  - rd_valid never drops without a handshake.
  - Throughput: one sample per cycle under continuous rd_ready.
  - rd_last=1 only with the DEPTH-th sample.
  - The cycle after the last handshake: done=1 for one cycle, rd_valid=0, state IDLE.
- adc_valid is ignored in READOUT and IDLE; no sample writes occur there.
- Record order: samples 0..P-1 are pre-trigger, sample P is the trigger sample, samples P+1..DEPTH-1 are post-trigger.
- Counters are DEPTH_LOG2+1 bits wide; there is no overflow at P = DEPTH-1.

Test Plan (DEPTH_LOG2=4, DEPTH=16):
- Ramp 0,1,2,... on every cycle; trig_level=20, rising, P=4 → trigger on sample 20; trig_pos=20 mod 16=4; readout = 16..31; rd_last with 31; one done pulse.
- Same ramp, falling, level=20 → no trigger, busy stays 1. Then force_trig with adc_valid=0 → fires on the next valid sample; record ends at that sample+11.
- P=0, first sample after arm = 50 with level=10 → no trigger (prev invalid). Second sample 5, third 15 → trigger on 15, which is record element 0.
- P=15, rising crossing at sample value 100 → record element 15 = 100; POST_FILL is skipped; readout begins 2 cycles after trigger.
- rd_ready toggling 1,0,0,1 during readout → rd_data holds across stalls; 16 handshakes total; no duplicated or dropped samples.
- rst pulse mid-POST_FILL → next cycle busy=0 and rd_valid=0. A new arm then completes a clean capture; arm pulses during READOUT are ignored.
